// File: rtl/seq_divider_2n_by_n_if.sv
// Operand/result handshake bundle for the 2N-by-N sequential divider.
interface seq_divider_2n_by_n_if #(
    parameter int N = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [2*N-1:0]     y;
    logic [N-1:0]       B;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       A;
    logic [N-1:0]       R;
    logic               div_zero;
    logic               ovf;

    modport master (
        output in_valid, y, B, out_ready,
        input  in_ready, out_valid, A, R, div_zero, ovf
    );

    modport slave (
        input  in_valid, y, B, out_ready,
        output in_ready, out_valid, A, R, div_zero, ovf
    );
endinterface

// File: rtl/seq_divider_2n_by_n.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per cycle, valid/ready on both sides.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   RUN   | shifting/subtracting, cnt quotient bits left to produce
//   DONE  | result presented, held until out_ready
module seq_divider_2n_by_n #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_divider_2n_by_n_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N-1:0]       rem;
    logic [N-1:0]       qsh;
    logic [N-1:0]       dsr;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               zero_b;
    logic               too_big;
    logic [N:0]         t;
    logic               ge;
    logic [N-1:0]       rem_nxt;
    logic [N-1:0]       qsh_nxt;
    logic               last_iter;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    assign accept    = bus.in_valid & (state == IDLE);
    assign zero_b    = (bus.B == '0);
    assign too_big   = (bus.y[2*N-1:N] >= bus.B);
    assign last_iter = (cnt == CNT_W'(1));

    // One restoring step: the partial remainder stays below dsr, so the
    // subtraction result always fits back into N bits.
    always_comb begin
        t       = {rem, qsh[N-1]};
        ge      = (t >= {1'b0, dsr});
        rem_nxt = ge ? (t[N-1:0] - dsr) : t[N-1:0];
        qsh_nxt = {qsh[N-2:0], ge};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; degenerate operands skip straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (zero_b || too_big) state_nxt = DONE;
                    else                   state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem          <= '0;
            qsh          <= '0;
            dsr          <= '0;
            cnt          <= '0;
            bus.A        <= '0;
            bus.R        <= '0;
            bus.div_zero <= 1'b0;
            bus.ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (zero_b) begin
                            bus.div_zero <= 1'b1;
                            bus.ovf      <= 1'b0;
                            bus.A        <= '1;
                            bus.R        <= '0;
                        end else if (too_big) begin
                            bus.div_zero <= 1'b0;
                            bus.ovf      <= 1'b1;
                            bus.A        <= '1;
                            bus.R        <= '0;
                        end else begin
                            rem          <= bus.y[2*N-1:N];
                            qsh          <= bus.y[N-1:0];
                            dsr          <= bus.B;
                            cnt          <= CNT_W'(N);
                            bus.div_zero <= 1'b0;
                            bus.ovf      <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    qsh <= qsh_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (last_iter) begin
                        bus.A <= qsh_nxt;
                        bus.R <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_2n_by_n.sv
// Self-checking bench for seq_divider_2n_by_n: directed cases, backpressure,
// mid-operation reset and a randomised sweep against a plain-arithmetic model.
module tb_seq_divider_2n_by_n;
    localparam int N    = 8;
    localparam int NOPS = 1500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_divider_2n_by_n_if #(.N(N)) bus ();
    seq_divider_2n_by_n #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: quotient/remainder straight from integer division.
    task automatic model(input int yv, input int bv, output int ea, output int er,
                         output bit edz, output bit eovf);
        edz = 0; eovf = 0;
        if (bv == 0) begin
            edz = 1; ea = (1 << N) - 1; er = 0;
        end else if (yv / bv >= (1 << N)) begin
            eovf = 1; ea = (1 << N) - 1; er = 0;
        end else begin
            ea = yv / bv; er = yv % bv;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.out_ready = 0; bus.y = '0; bus.B = '0;
        repeat (3) tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.A !== 0 ||
            bus.R !== 0 || bus.div_zero !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b A=%0d R=%0d dz=%b ovf=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.A, bus.R, bus.div_zero, bus.ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    // Accepts one operand pair and returns edges from the accept edge until out_valid.
    task automatic start_op(input int yv, input int bv, output int lat);
        int guard;
        guard = 0;
        bus.y = yv[2*N-1:0]; bus.B = bv[N-1:0]; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    endtask

    task automatic directed(input string name, input int yv, input int bv, input int ea,
                            input int er, input bit edz, input bit eovf, input int elat);
        int lat;
        bus.out_ready = 1'b1;
        start_op(yv, bv, lat);
        checks++;
        if (lat != elat || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges (out_valid=%b), want %0d", name, lat, bus.out_valid, elat);
        end
        checks++;
        if (bus.A !== ea[N-1:0] || bus.R !== er[N-1:0] || bus.div_zero !== edz || bus.ovf !== eovf) begin
            errors++;
            $display("FAIL %s_result: got A=%0d R=%0d dz=%b ovf=%b, want A=%0d R=%0d dz=%b ovf=%b",
                     name, bus.A, bus.R, bus.div_zero, bus.ovf, ea, er, edz, eovf);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_handoff: got in_ready=%b out_valid=%b, want 1 0", name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        directed("normal",      28600, 200, 143,   0, 0, 0, N);
        directed("max_no_ovf",  65279, 255, 255, 254, 0, 0, N);
        directed("div_zero",     1234,   0, 255,   0, 1, 0, 0);
        directed("overflow",   'h1000, 'h10, 255,  0, 0, 1, 0);
        directed("ovf_bound",  'h0FFF, 'h10, 255, 'h0F, 0, 0, N);
    endtask

    task automatic test_backpressure();
        int lat;
        bit bad;
        bus.out_ready = 1'b0;
        start_op(100, 7, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.A !== 14 || bus.R !== 2)
                bad = 1;
            tick();
        end
        checks++;
        if (bad || bus.out_valid !== 1'b1 || bus.A !== 14 || bus.R !== 2) begin
            errors++;
            $display("FAIL backpressure_hold: got out_valid=%b in_ready=%b A=%0d R=%0d, want 1 0 14 2 held",
                     bus.out_valid, bus.in_ready, bus.A, bus.R);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit seen;
        bus.out_ready = 1'b1;
        bus.y = 16'd5000; bus.B = 8'd50; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: got in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_discard: got out_valid=1 after abort, want 0");
        end
        start_op(5000, 50, lat);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.A !== 100 || bus.R !== 0 || lat != N) begin
            errors++;
            $display("FAIL reset_restart: got out_valid=%b A=%0d R=%0d lat=%0d, want 1 100 0 %0d",
                     bus.out_valid, bus.A, bus.R, lat, N);
        end
        tick();
    endtask

    task automatic test_random();
        int q_y[$];
        int q_b[$];
        int received;
        bit drv_done;
        received = 0;
        drv_done = 0;
        fork
            begin : driver
                for (int i = 0; i < NOPS; i++) begin
                    int gap, mode, bv, hi, lo, guard;
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) begin
                        bus.in_valid = 1'b0;
                        bus.y = 16'($urandom); bus.B = 8'($urandom);
                        tick();
                    end
                    mode = $urandom_range(0, 9);
                    bv = $urandom_range(1, 255);
                    lo = $urandom_range(0, 255);
                    if (mode == 0) begin
                        bv = 0; hi = $urandom_range(0, 255);
                    end else if (mode == 1) begin
                        hi = bv + $urandom_range(0, 255 - bv);
                    end else if (mode == 2) begin
                        hi = $urandom_range(0, 255);
                    end else begin
                        hi = $urandom_range(0, bv - 1);
                    end
                    bus.y = 16'((hi << 8) | lo); bus.B = bv[7:0]; bus.in_valid = 1'b1;
                    guard = 0;
                    while (bus.in_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
                    if (guard >= 100) begin
                        checks++; errors++;
                        $display("FAIL random_accept_timeout: got in_ready=0 for 100 cycles, want 1");
                        break;
                    end
                    q_y.push_back((hi << 8) | lo);
                    q_b.push_back(bv);
                    tick();
                    bus.in_valid = 1'b0;
                end
                drv_done = 1;
            end
            begin : monitor
                int cyc;
                cyc = 0;
                while (received < NOPS && cyc < 60000) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                        checks++;
                        if (q_y.size() == 0) begin
                            errors++;
                            $display("FAIL random_extra_output: got result A=%0d with no pending op, want none", bus.A);
                        end else begin
                            int yv, bv, ea, er;
                            bit edz, eovf;
                            yv = q_y.pop_front(); bv = q_b.pop_front();
                            model(yv, bv, ea, er, edz, eovf);
                            if (bus.A !== ea[N-1:0] || bus.R !== er[N-1:0] ||
                                bus.div_zero !== edz || bus.ovf !== eovf) begin
                                errors++;
                                $display("FAIL random_result y=%0d B=%0d: got A=%0d R=%0d dz=%b ovf=%b, want A=%0d R=%0d dz=%b ovf=%b",
                                         yv, bv, bus.A, bus.R, bus.div_zero, bus.ovf, ea, er, edz, eovf);
                            end
                        end
                        received++;
                    end
                    tick();
                    cyc++;
                end
            end
        join
        checks++;
        if (received != NOPS || q_y.size() != 0 || !drv_done) begin
            errors++;
            $display("FAIL random_count: got %0d results (%0d pending), want %0d", received, q_y.size(), NOPS);
        end
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
